// File: rtl/aftab_readout_pkg.sv
// ----------------------------------------------------------------------------
// aftab_readout_pkg
// Shared definitions for the AFTAB debug readout engine.
//   - state_t : FSM state encoding (IDLE, SHIFT, PARITY, DONE)
//   - cnt_width() : width of the bit counter for a given captured width
// Optional feature macro: AFTAB_READOUT_PARITY_EN (even-parity trailer bit).
// ----------------------------------------------------------------------------
package aftab_readout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter must be able to index every data bit; sized to hold n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/aftab_readout_counter.sv
// ----------------------------------------------------------------------------
// aftab_readout_counter
// Parameterised up-counter with synchronous clear and count enable.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   i_clr   : synchronous clear (wins over i_en)
//   i_en    : increment enable
//   o_count : current count value
// ----------------------------------------------------------------------------
module aftab_readout_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count register: clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {W{1'b0}};
        end else if (i_clr) begin
            r_count <= {W{1'b0}};
        end else if (i_en) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/aftab_debug_readout.sv
// ----------------------------------------------------------------------------
// aftab_debug_readout
// Captures a parallel datapath value on request and shifts it out LSB-first
// over a per-bit valid/ready handshake to the debugger serial link.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in        : parallel value, sampled only on the capture edge
//   req       : capture request, honoured only in IDLE
//   zero      : synchronous abort/clear, forces IDLE
//   soutReady : debugger accepts current serial bit
//   sout      : current serial bit
//   soutValid : sout is valid
//   busy      : transfer in progress
//   done      : one-cycle pulse after the last bit is accepted
// Optional feature macro: AFTAB_READOUT_PARITY_EN appends an even-parity bit.
// ----------------------------------------------------------------------------
module aftab_debug_readout
    import aftab_readout_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] in,
    input  logic            req,
    input  logic            zero,
    input  logic            soutReady,
    output logic            sout,
    output logic            soutValid,
    output logic            busy,
    output logic            done
);

    localparam int             CW   = cnt_width(size);
    localparam logic [CW-1:0]  LAST = CW'(size - 1);

    state_t          r_state;
    logic [size-1:0] r_shreg;
    logic [CW-1:0]   w_count;
    logic            w_capture;
    logic            w_accept;
    logic            w_last;
    logic            w_cnt_clr;
    logic            w_cnt_en;

    assign w_capture = (r_state == IDLE) && req && !zero;
    assign w_accept  = (r_state == SHIFT) && soutReady;
    assign w_last    = (w_count == LAST);
    // Counter parks at size-1 rather than wrapping; capture restarts it.
    assign w_cnt_clr = zero || w_capture;
    assign w_cnt_en  = w_accept && !w_last;

    aftab_readout_counter #(
        .W (CW)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

`ifdef AFTAB_READOUT_PARITY_EN
    logic r_par;

    // Parity accumulator: even parity of the captured word, fixed at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (zero) begin
            r_par <= 1'b0;
        end else if (w_capture) begin
            r_par <= ^in;
        end else begin
            r_par <= r_par;
        end
    end
`endif

    // Transfer FSM and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= {size{1'b0}};
        end else if (zero) begin
            r_state <= IDLE;
            r_shreg <= {size{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_shreg <= in;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (soutReady) begin
                        r_shreg <= {1'b0, r_shreg[size-1:1]};
                        if (w_last) begin
`ifdef AFTAB_READOUT_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= DONE;
`endif
                        end else begin
                            r_state <= SHIFT;
                        end
                    end else begin
                        r_state <= SHIFT;
                    end
                end
`ifdef AFTAB_READOUT_PARITY_EN
                PARITY: begin
                    if (soutReady) begin
                        r_state <= DONE;
                    end else begin
                        r_state <= PARITY;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state, so rst clears them at once.
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
`ifdef AFTAB_READOUT_PARITY_EN
    assign soutValid = (r_state == SHIFT) || (r_state == PARITY);
    assign sout      = ((r_state == SHIFT) && r_shreg[0]) ||
                       ((r_state == PARITY) && r_par);
`else
    assign soutValid = (r_state == SHIFT);
    assign sout      = (r_state == SHIFT) && r_shreg[0];
`endif

endmodule

// File: tb/tb_aftab_debug_readout.sv
module tb_aftab_debug_readout;

`ifdef AFTAB_READOUT_PARITY_EN
    localparam int PEXTRA = 1;
`else
    localparam int PEXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_s = 8'h00;
    logic       req = 1'b0;
    logic       zero = 1'b0;
    logic       soutReady = 1'b1;
    logic       sout, soutValid, busy, done;

    int   n_cmp = 0;
    int   n_mis = 0;
    logic exp_bits[$];
    int   exp_done = 0;

    aftab_debug_readout #(.size(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_s),
        .req       (req),
        .zero      (zero),
        .soutReady (soutReady),
        .sout      (sout),
        .soutValid (soutValid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected bits on every accepted handshake and tracks done.
    always @(negedge clk) begin
        if (!rst) begin
            if (soutValid && soutReady) begin
                if (exp_bits.size() == 0) begin
                    chk("unexpected_bit", 32'(sout), 32'hDEAD);
                end else begin
                    chk("sout_bit", 32'(sout), 32'(exp_bits.pop_front()));
                end
            end
            if (done) begin
                chk("done_expected", 32'(exp_done > 0), 32'd1);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    // Push expected serial stream written in transmission order ("1" = high).
    task automatic push_seq(input string seq);
        for (int i = 0; i < seq.len(); i++) exp_bits.push_back(seq[i] == 8'h31);
    endtask

    task automatic xfer(input logic [7:0] val, input string seq, input logic pbit,
                        input int st_start, input int st_len, input bit repulse,
                        input int exp_done_cyc);
        int found;
        found = 0;
        push_seq(seq);
        if (PEXTRA == 1) exp_bits.push_back(pbit);
        exp_done++;
        in_s = val; req = 1'b1; soutReady = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int cyc = 1; cyc <= 40 && found == 0; cyc++) begin
            soutReady = !(cyc >= st_start && cyc < st_start + st_len);
            if (repulse) begin
                req = (cyc == 4);
                if (cyc == 4) in_s = 8'hC3;
            end
            @(negedge clk);
            chk("busy_during", 32'(busy), 32'd1);
            if (!soutReady) begin
                chk("stall_valid", 32'(soutValid), 32'd1);
                chk("stall_sout", 32'(sout), 32'(seq[st_start-1] == 8'h31));
            end
            if (done) found = cyc;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("done_cycle", 32'(found), 32'(exp_done_cyc));
        soutReady = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(soutValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst_sout", 32'(sout), 32'd0);
        chk("rst_valid", 32'(soutValid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Basic transfer, A5
        xfer(8'hA5, "10100101", 1'b0, 0, 0, 1'b0, 9 + PEXTRA);
        // Parity-relevant value 07
        xfer(8'h07, "11100000", 1'b1, 0, 0, 1'b0, 9 + PEXTRA);
        // Backpressure: 3 stall cycles while bit 2 is presented (cycle 3)
        xfer(8'hA5, "10100101", 1'b0, 3, 3, 1'b0, 12 + PEXTRA);

        // zero while bit 4 is presented: abort, no done
        push_seq("1010");
        in_s = 8'hA5; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (cyc == 5) begin
                zero = 1'b1; soutReady = 1'b0;
            end
            @(posedge clk); #1;
        end
        zero = 1'b0; soutReady = 1'b1;
        @(negedge clk);
        chk("zero_valid", 32'(soutValid), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        xfer(8'h3C, "00111100", 1'b0, 0, 0, 1'b0, 9 + PEXTRA);

        // req re-pulsed with new in mid-transfer: stream unaffected
        xfer(8'hA5, "10100101", 1'b0, 0, 0, 1'b1, 9 + PEXTRA);
        xfer(8'hC3, "11000011", 1'b0, 0, 0, 1'b0, 9 + PEXTRA);

        // Asynchronous reset mid-SHIFT
        push_seq("01");
        in_s = 8'h96; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 rst = 1'b1;
        #1;
        chk("arst_sout", 32'(sout), 32'd0);
        chk("arst_valid", 32'(soutValid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        xfer(8'h96, "01101001", 1'b0, 0, 0, 1'b0, 9 + PEXTRA);

        repeat (3) @(posedge clk);
        #1;
        chk("bits_left", 32'(exp_bits.size()), 32'd0);
        chk("done_left", 32'(exp_done), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/aftab_debug_readout.md
# aftab_debug_readout

Bit-serial readout engine for the AFTAB debugger path. It captures a parallel datapath value, such as a register output, in one cycle on request. It then shifts the value out LSB-first over a per-bit valid/ready handshake to the debugger's serial link, so the debugger can read back values that datapath registers have written.

## Interface

Parameters:
- size, 32, width of the captured parallel value; legal range is size >= 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in  input  size  parallel value sampled on the capture edge.
- req  input  1  capture request; honoured only in IDLE.
- zero  input  1  synchronous abort and clear; forces IDLE.
- soutReady  input  1  debugger accepts the current serial bit.
- sout  output  1  current serial bit.
- soutValid  output  1  sout is valid.
- busy  output  1  transfer in progress (state != IDLE).
- done  output  1  one-cycle pulse after the last bit is accepted.

## Operation

- States: IDLE, SHIFT, PARITY (present only with the macro), DONE.
- IDLE:
  - Outputs: soutValid=0, busy=0, done=0.
  - When req=1: load the shift register with in, clear the bit counter, go to SHIFT.
- SHIFT:
  - soutValid=1, sout=shreg[0].
  - On soutValid && soutReady: shift right by 1 (zero fill) and increment the counter.
  - On acceptance of bit index size-1: go to PARITY if enabled, else DONE.
- PARITY:
  - soutValid=1, sout = XOR of all captured bits (even parity).
  - On soutReady: go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- No handshake while soutReady=0: sout, the shift register and the counter hold.
- Counter width is $clog2(size+1). The counter never wraps: it stops at size-1 and is cleared on capture.
- Input handling:
  - in is ignored except on the capture edge.
  - req is ignored in SHIFT, PARITY and DONE; it is not queued.
- Priority: rst > zero > state logic.
  - zero=1 in any state: next state IDLE, shift register, counter and parity cleared, no done pulse.
  - zero and req asserted together: zero wins and no capture occurs.

## Timing

- Reset values: sout=0, soutValid=0, busy=0, done=0, state IDLE, shift register 0, counter 0.
- Latency with soutReady held at 1:
  - req sampled at edge 0 → bit 0 valid in cycle 1.
  - Bit k is valid in cycle k+1.
  - done is high in cycle size+1, or size+2 with parity.
  - Back in IDLE one cycle later, where the next req is accepted.
- Each bit stays valid at least one cycle. Bit stretching equals the number of cycles with soutReady low.
- All outputs are decoded from registered state and the shift register, with no combinational path from inputs. soutReady affects only the next state.
- rst asserted mid-transfer: outputs go to reset values immediately, not at the next edge. The transfer is discarded.

## Configuration

- AFTAB_READOUT_PARITY_EN defined: the PARITY state exists. One extra even-parity bit follows the data, and done is delayed by one accepted bit.
- Not defined: there is no PARITY state or parity logic. Exactly size bits are sent, and DONE follows the last data bit directly.

## Structure

- Shared package aftab_readout_pkg:
  - State encoding constants IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, DONE=2'd3.
  - The counter-width function.
- One sub-module, aftab_readout_counter: a parameterised up-counter with clear and enable, reset asynchronously by rst.
- The top level contains the shift register, the FSM and the parity accumulator.

## Test plan

- size=8, in=8'hA5, req pulse, soutReady=1 → sout sequence 1,0,1,0,0,1,0,1 in cycles 1–8; done in cycle 9; busy cycles 1–9.
- With AFTAB_READOUT_PARITY_EN, in=8'h07 → data bits 1,1,1,0,0,0,0,0 then parity bit 1; done in cycle 10. Repeat with 8'hA5 → parity bit 0.
- Backpressure: soutReady low for 3 cycles while bit 2 is presented → sout, soutValid and the counter hold for those cycles; total transfer is 3 cycles longer and the bit order is unchanged.
- zero asserted at bit 4 → IDLE next cycle, soutValid=0, no done pulse. A new req then transfers a fresh value from bit 0.
- req re-pulsed and in changed mid-transfer → no effect on the serial stream. After DONE, a req in IDLE captures the new value.
- rst asserted asynchronously mid-SHIFT → outputs go to 0 without waiting for a clock edge. After release, the FSM is in IDLE and a req-driven transfer completes normally.
